// File: rtl/mult_pkg.sv
// Shared types and defaults for the shift-and-add multiplier controller.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t;

  localparam int MULT_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/adder_nbit.sv
// Ripple-carry adder built as a chain of 1-bit full adders.
module adder_nbit #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] sum,
  output logic             Cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]     = A[i] ^ B[i] ^ carry[i];
    assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
  end

  assign Cout = carry[WIDTH];

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Multi-cycle unsigned shift-and-add multiplier sharing one 2*WIDTH-bit adder.
// Optional build macro MULT_EARLY_EXIT_EN finishes as soon as no multiplier bits remain.
module shift_add_mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mult_state_t   state_q, state_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] add_sum;
  logic          unused_cout;
  logic          last_step;

  // Carry-out is dropped: the product of two WIDTH-bit operands fits in PW bits.
  adder_nbit #(.WIDTH(PW)) u_adder (
    .A   (acc_q),
    .B   (mcand_q),
    .Cin (1'b0),
    .sum (add_sum),
    .Cout(unused_cout)
  );

`ifdef MULT_EARLY_EXIT_EN
  assign last_step = (count_q == LAST) || (mq_q[WIDTH-1:1] == '0);
`else
  assign last_step = (count_q == LAST);
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mq_d    = mq_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d = {{WIDTH{1'b0}}, a};
          mq_d    = b;
          acc_d   = '0;
          count_d = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (mq_q[0]) acc_d = add_sum;
        mcand_d = mcand_q << 1;
        mq_d    = mq_q >> 1;
        count_d = count_q + CW'(1);
        if (last_step) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      mq_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mq_q    <= mq_d;
      count_q <= count_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = acc_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed and randomised bench for the shift-and-add multiplier controller.
module tb_shift_add_mult_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [2*W-1:0] product;

  int vecs;
  int errs;

  shift_add_mult_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product)
  );

  initial clk = 1'b0;
  always #500 clk = ~clk;

  function automatic int exp_lat(input logic [W-1:0] bb);
`ifdef MULT_EARLY_EXIT_EN
    int h;
    h = 0;
    for (int i = 0; i < W; i++) if (bb[i]) h = i + 1;
    return (h == 0) ? 1 : h;
`else
    return W;
`endif
  endfunction

  // Presents one operand pair at a negedge; returns at the negedge where out_valid
  // is first seen. lat = number of edges after the accepting edge, -1 on timeout.
  task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb,
                        output logic [2*W-1:0] p, output int lat);
    a = aa;
    b = bb;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (out_valid !== 1'b1) lat = -1;
    p = product;
  endtask

  task automatic test_reset();
    logic [2*W-1:0] p;
    int lat;
    @(negedge clk);
    reset = 1'b1;
    #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_idle_in_ready got %b want 1", in_ready); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_idle_out_valid got %b want 0", out_valid); end
    vecs++; if (product !== '0) begin errs++; $display("FAIL rst_idle_product got %h want 0", product); end
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b0;
    run_op(8'd2, 8'd3, p, lat);
    vecs++; if (out_valid !== 1'b1 || p !== 16'd6) begin errs++; $display("FAIL rst_pre_done got valid=%b p=%0d want 1,6", out_valid, p); end
    reset = 1'b1;
    #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_done_in_ready got %b want 1", in_ready); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_done_out_valid got %b want 0", out_valid); end
    vecs++; if (product !== '0) begin errs++; $display("FAIL rst_done_product got %h want 0", product); end
    @(negedge clk);
    vecs++; if (out_valid !== 1'b0 || product !== '0) begin errs++; $display("FAIL rst_hold got valid=%b p=%h want 0,0", out_valid, product); end
    reset = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_basic();
    logic [2*W-1:0] p;
    int lat;
    out_ready = 1'b1;
    run_op(8'd13, 8'd11, p, lat);
    vecs++; if (p !== 16'd143) begin errs++; $display("FAIL basic_product got %0d want 143", p); end
    vecs++; if (lat != exp_lat(8'd11)) begin errs++; $display("FAIL basic_latency got %0d want %0d", lat, exp_lat(8'd11)); end
    @(negedge clk);
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL basic_one_cycle got out_valid=%b want 0", out_valid); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL basic_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_corners();
    logic [2*W-1:0] p;
    int lat;
    out_ready = 1'b1;
    run_op(8'hFF, 8'hFF, p, lat);
    vecs++; if (p !== 16'hFE01) begin errs++; $display("FAIL ff_x_ff got %h want fe01", p); end
    vecs++; if (lat != W) begin errs++; $display("FAIL ff_latency got %0d want %0d", lat, W); end
    @(negedge clk);
    run_op(8'h80, 8'h02, p, lat);
    vecs++; if (p !== 16'h0100) begin errs++; $display("FAIL 80_x_02 got %h want 0100", p); end
    @(negedge clk);
    run_op(8'd3, 8'h80, p, lat);
    vecs++; if (p !== 16'd384) begin errs++; $display("FAIL 3_x_80 got %0d want 384", p); end
    vecs++; if (lat != W) begin errs++; $display("FAIL msb_b_latency got %0d want %0d", lat, W); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [2*W-1:0] p;
    int lat;
    out_ready = 1'b0;
    run_op(8'd3, 8'd3, p, lat);
    vecs++; if (p !== 16'd9) begin errs++; $display("FAIL bp_product got %0d want 9", p); end
    a = 8'd5;
    b = 8'd5;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vecs++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== 16'd9) begin
        errs++;
        $display("FAIL bp_hold cyc %0d got valid=%b rdy=%b p=%0d want 1,0,9", i, out_valid, in_ready, product);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    vecs++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errs++; $display("FAIL bp_release got rdy=%b valid=%b want 1,0", in_ready, out_valid); end
    run_op(8'd3, 8'd3, p, lat);
    vecs++; if (p !== 16'd9) begin errs++; $display("FAIL bp_next got %0d want 9", p); end
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    logic [2*W-1:0] p;
    int lat;
    int seen;
    out_ready = 1'b1;
    a = 8'd200;
    b = 8'd100;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    vecs++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errs++; $display("FAIL midop_reset got rdy=%b valid=%b want 1,0", in_ready, out_valid); end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    vecs++; if (seen != 0) begin errs++; $display("FAIL midop_no_valid got %0d pulses want 0", seen); end
    run_op(8'd7, 8'd6, p, lat);
    vecs++; if (p !== 16'd42) begin errs++; $display("FAIL midop_next got %0d want 42", p); end
    @(negedge clk);
  endtask

  task automatic test_zero();
    logic [2*W-1:0] p;
    int lat;
    out_ready = 1'b1;
    run_op(8'd5, 8'd0, p, lat);
    vecs++; if (p !== 16'd0) begin errs++; $display("FAIL zero_product got %0d want 0", p); end
`ifdef MULT_EARLY_EXIT_EN
    vecs++; if (lat != 1) begin errs++; $display("FAIL zero_latency got %0d want 1", lat); end
`else
    vecs++; if (lat != 8) begin errs++; $display("FAIL zero_latency got %0d want 8", lat); end
`endif
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [2*W-1:0] p;
    logic [2*W-1:0] want;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int lat;
    out_ready = 1'b1;
    for (int n = 0; n < 500; n++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      want = {{W{1'b0}}, ra} * {{W{1'b0}}, rb};
      run_op(ra, rb, p, lat);
      vecs++;
      if (p !== want || lat != exp_lat(rb)) begin
        errs++;
        $display("FAIL rand %0d*%0d got p=%0d lat=%0d want p=%0d lat=%0d", ra, rb, p, lat, want, exp_lat(rb));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_reset_midop();
    test_zero();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
